// File: rtl/w_update_pkg.sv
// Shared definitions for the weight-update sequencer.
//  - state_e   : sweep FSM encoding (IDLE/RUN/DONE)
//  - round_c() : round-half-up constant 1<<(qp-1) added before dropping qp bits
//  - sat_max() / sat_min() : clamp limits for a width-bit two's-complement value
// Optional feature macro used by the importers: W_UPDATE_SAT_EN.
package w_update_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic longint round_c(input int qp);
    return longint'(1) <<< (qp - 1);
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/w_update_seq_if.sv
// Bus between the filter top-level (master) and the weight-update sequencer (slave).
// Handshake: start is a single-cycle request; it is accepted on the rising edge only
// when busy==0, otherwise it is dropped and overrun pulses in the same cycle.
// x_idx/x_in form a combinational fetch: slave presents x_idx, master returns
// x_in = x[x_idx] in the same cycle. w_rd_idx/w_rd_data is a combinational read port.
// dbg_state exposes the sweep FSM for observation.
interface w_update_seq_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 3
);
  logic             start;
  logic [WIDTH-1:0] mu_error;
  logic [IDX_W-1:0] x_idx;
  logic [WIDTH-1:0] x_in;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [IDX_W-1:0] w_rd_idx;
  logic [WIDTH-1:0] w_rd_data;
  logic [1:0]       dbg_state;

  modport master (
    output start, mu_error, x_in, w_rd_idx,
    input  x_idx, busy, done, overrun, w_rd_data, dbg_state
  );

  modport slave (
    input  start, mu_error, x_in, w_rd_idx,
    output x_idx, busy, done, overrun, w_rd_data, dbg_state
  );
endinterface

// File: rtl/w_update_alu.sv
// Combinational weight update: w_new = w_old + round(x_in * mu).
// The product is 2*WIDTH bits, rounded half-up at bit QP, and the WIDTH bits
// above the fraction form the increment.
// Ports: w_old (current weight), x_in (sample), mu (mu_error), w_new (result).
// Macro W_UPDATE_SAT_EN: when defined the add saturates instead of wrapping.
module w_update_alu
  import w_update_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int QP    = 12
) (
  input  logic [WIDTH-1:0] w_old,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] mu,
  output logic [WIDTH-1:0] w_new
);
  localparam logic signed [2*WIDTH-1:0] RND = (2*WIDTH)'(round_c(QP));

  logic signed [2*WIDTH-1:0] x_ext;
  logic signed [2*WIDTH-1:0] mu_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] rnd;
  logic        [WIDTH-1:0]   inc;
  logic                      unused_rnd_bits;

  assign x_ext  = {{WIDTH{x_in[WIDTH-1]}}, x_in};
  assign mu_ext = {{WIDTH{mu[WIDTH-1]}}, mu};
  assign prod   = x_ext * mu_ext;
  assign rnd    = prod + RND;
  assign inc    = rnd[QP+WIDTH-1:QP];
  // Fraction bits and the product's top guard bits are intentionally discarded.
  assign unused_rnd_bits = ^{rnd[QP-1:0], rnd[2*WIDTH-1:QP+WIDTH]};

`ifdef W_UPDATE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));
  logic [WIDTH:0] sum_ext;

  assign sum_ext = {w_old[WIDTH-1], w_old} + {inc[WIDTH-1], inc};

  // The two top bits disagree only when the true sum left the WIDTH-bit range;
  // the extra sign bit tells which side it left on.
  always_comb begin
    w_new = sum_ext[WIDTH-1:0];
    if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
      w_new = sum_ext[WIDTH] ? SAT_LO : SAT_HI;
    end
  end
`else
  assign w_new = w_old + inc;
`endif
endmodule

// File: rtl/w_update_seq.sv
// Weight-update sequencer: one start runs a sweep that updates every tap
// weight[i] += round(x[i] * mu_error) using a single shared ALU.
// Ports: clk, reset (synchronous, active-low), bus (w_update_seq_if.slave:
// start/mu_error request, x_idx/x_in sample fetch, busy/done/overrun status,
// w_rd_idx/w_rd_data weight read port, dbg_state FSM state).
// Sweep: IDLE -> RUN (one tap per cycle) -> DONE (one cycle) -> IDLE,
// giving a period of NTAPS+2 cycles.
// Macro W_UPDATE_SAT_EN: saturating instead of wrapping weight add (in the ALU).
module w_update_seq
  import w_update_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int NTAPS     = 8,
  parameter int IDX_W     = $clog2(NTAPS),
  parameter int RESET_VAL = 0
) (
  input  logic           clk,
  input  logic           reset,
  w_update_seq_if.slave  bus
);
  localparam logic [1:0]       IDLE  = ST_IDLE;
  localparam logic [1:0]       RUN   = ST_RUN;
  localparam logic [1:0]       DONE  = ST_DONE;
  localparam logic [WIDTH-1:0] W_RST = WIDTH'(RESET_VAL <<< QP);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NTAPS - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] mu_q, mu_d;
  logic [WIDTH-1:0] wreg_q [NTAPS];
  logic [WIDTH-1:0] wreg_d [NTAPS];
  logic [WIDTH-1:0] alu_w_new;

  w_update_alu #(
    .WIDTH(WIDTH),
    .QP   (QP)
  ) u_alu (
    .w_old(wreg_q[idx_q]),
    .x_in (bus.x_in),
    .mu   (mu_q),
    .w_new(alu_w_new)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mu_d    = mu_q;
    wreg_d  = wreg_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mu_d    = bus.mu_error;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        wreg_d[idx_q] = alu_w_new;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mu_q    <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        wreg_q[i] <= W_RST;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mu_q    <= mu_d;
      wreg_q  <= wreg_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  // A start during reset is dropped entirely, so it does not count as an overrun.
  assign bus.overrun   = bus.start && bus.busy && reset;
  assign bus.x_idx     = (state_q == RUN) ? idx_q : '0;
  assign bus.dbg_state = state_q;
  // Reads see the registers, so the tap being written this cycle returns its old value.
  assign bus.w_rd_data = (32'(bus.w_rd_idx) < NTAPS) ? wreg_q[bus.w_rd_idx] : '0;
endmodule

// File: tb/tb_w_update_seq.sv
module tb_w_update_seq;
  localparam int W     = 16;
  localparam int NT    = 8;
  localparam int IDXW  = 3;

  logic clk;
  logic reset;
  logic rd_valid;
  logic [W-1:0] x_mem [NT];

  logic [W-1:0] exp_q[$];
  int           exp_idx_q[$];
  int           errors;
  int           checks;

  w_update_seq_if #(.WIDTH(W), .IDX_W(IDXW)) bus ();

  w_update_seq #(
    .WIDTH    (W),
    .QP       (12),
    .NTAPS    (NT),
    .IDX_W    (IDXW),
    .RESET_VAL(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Combinational delay-line model answering the sample fetch.
  assign bus.x_in = x_mem[bus.x_idx];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: whenever the bench presents a read, pop and compare.
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: idx %0d data 0x%0h with empty queue", bus.w_rd_idx, bus.w_rd_data);
      end else begin
        automatic logic [W-1:0] e = exp_q.pop_front();
        automatic int           ei = exp_idx_q.pop_front();
        if (bus.w_rd_data !== e) begin
          errors++;
          $display("FAIL weight[%0d]: got 0x%0h expected 0x%0h", ei, bus.w_rd_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic read_expect(input int idx, input logic [W-1:0] e);
    bus.w_rd_idx = IDXW'(idx);
    exp_q.push_back(e);
    exp_idx_q.push_back(idx);
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic read_all(input logic [W-1:0] e [NT]);
    for (int i = 0; i < NT; i++) read_expect(i, e[i]);
  endtask

  task automatic set_x_all(input logic [W-1:0] v);
    for (int i = 0; i < NT; i++) x_mem[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_x_idx", 32'(bus.x_idx), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    reset = 1'b1;
  endtask

  // Cycle n counts cycles after the start cycle: cycle 1 follows the accepting edge.
  // ovr_at/rst_at select the cycle where a stray start or a reset is injected (0 = none).
  task automatic run_sweep(input logic [W-1:0] mu, input int ovr_at, input int rst_at);
    int n;
    bus.mu_error = mu;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    while (!bus.done && n < 30) begin
      if (n == ovr_at) begin
        bus.start    = 1'b1;
        bus.mu_error = mu ^ 16'h1800;
        #1;
        check("overrun_pulse", 32'(bus.overrun), 32'd1);
        tick();
        n++;
        bus.start    = 1'b0;
        bus.mu_error = mu;
        #1;
        check("overrun_clear", 32'(bus.overrun), 32'd0);
      end else if (n == rst_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_x_idx", 32'(bus.x_idx), 32'd0);
        return;
      end else begin
        tick();
        n++;
      end
    end
    if (!bus.done) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end else begin
      check("done_latency", 32'(n), 32'd9);
    end
    tick();
    check("done_single_cycle", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  logic [W-1:0] e_vec [NT];
  logic [W-1:0] ovf_exp;

  initial begin
    errors       = 0;
    checks       = 0;
    rd_valid     = 1'b0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.mu_error = '0;
    bus.w_rd_idx = '0;
    set_x_all(16'h0000);

    do_reset();
    e_vec = '{default: 16'h0000};
    read_all(e_vec);

    // 1.0 * 0.5 on every tap
    set_x_all(16'h1000);
    run_sweep(16'h0800, 0, 0);
    e_vec = '{default: 16'h0800};
    read_all(e_vec);

    // -1.0 * 0.5 cancels the previous sweep
    set_x_all(16'hF000);
    run_sweep(16'h0800, 0, 0);
    e_vec = '{default: 16'h0000};
    read_all(e_vec);

    // Distinct per-tap samples, mu = 0.5: inc = floor((x + 1) / 2)
    x_mem = '{16'h0001, 16'h1000, 16'hF000, 16'h2000, 16'h0003, 16'hFFFF, 16'h0800, 16'h0000};
    run_sweep(16'h0800, 0, 0);
    e_vec = '{16'h0001, 16'h0800, 16'hF800, 16'h1000, 16'h0002, 16'h0000, 16'h0400, 16'h0000};
    read_all(e_vec);

    // Just below the rounding threshold: inc = 0, weights unchanged
    set_x_all(16'h0001);
    run_sweep(16'h07FF, 0, 0);
    read_all(e_vec);

    // Overflow: 0x7F00 + 0x0800
    do_reset();
    set_x_all(16'h7F00);
    run_sweep(16'h1000, 0, 0);
    e_vec = '{default: 16'h7F00};
    read_all(e_vec);
    set_x_all(16'h1000);
    run_sweep(16'h0800, 0, 0);
`ifdef W_UPDATE_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'h8700;
`endif
    e_vec = '{default: ovf_exp};
    read_all(e_vec);

    // Stray start in cycle 3 of a sweep: ignored, mu unchanged
    do_reset();
    set_x_all(16'h1000);
    run_sweep(16'h0800, 3, 0);
    e_vec = '{default: 16'h0800};
    read_all(e_vec);
    tick();
    check("no_second_sweep", 32'(bus.busy), 32'd0);

    // Reset in cycle 4 aborts the sweep and clears all weights
    run_sweep(16'h0800, 0, 4);
    e_vec = '{default: 16'h0000};
    read_all(e_vec);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
